core_ex: RTL and testbench
==========================

# core_ex

Execute stage of the xRV32I pipeline, consuming the operands, ALU function and decoded fields registered by the ID/EX pipeline register. It computes ALU results, resolves branches and jumps, and registers its results toward the EX/MEM boundary. Shifts (SLL/SRL/SRA) run on an area-saving bit-serial shifter that takes multiple cycles and stalls upstream through `hold_req_out`.

## Interface
- `SERIAL_SHIFT`, default 1: 1 selects the bit-serial shifter. 0 selects a single-cycle barrel shift.
- `clk` input 1: clock, rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `inst_addr_in` input `InstAddressBus`: PC of the instruction.
- `reg_we_in` input 1: write-back enable.
- `reg_write_addr_in` input `RegistersAddressBus`: rd.
- `reg1_data_in`, `reg2_data_in` input 32 each: rs1 and rs2 values, used for branch compare.
- `eval_en_in` input 1: ALU enable.
- `opnum1_in`, `opnum2_in` input 32 each: ALU operands.
- `func_in` input `ALUFuncBus`: ALU function, using the `ALUFunc_*` codes.
- `opcode_in` input `INST_OPCODEBus`: instruction opcode.
- `func3_in` input `INST_FUNC3Bus`: func3 field.
- `immB_in`, `immJ_in`, `immI_in` input 32 each: sign-extended immediates.
- `flush_in` input 1: kill the current instruction and abort any shift in progress.
- `reg_we_out` output 1: registered write-back enable.
- `reg_write_addr_out` output `RegistersAddressBus`: registered rd.
- `result_out` output 32: registered result.
- `valid_out` output 1: result and write-back fields are meaningful this cycle.
- `jump_flag_out` output 1: registered redirect request.
- `jump_addr_out` output `InstAddressBus`: redirect target.
- `hold_req_out` output 1: stall request for PC, IF/ID and ID/EX.

## Operation
- FSM states: IDLE and SHIFT. Reset state is IDLE.
- In IDLE, each clock edge samples the inputs.
  - ALU ops (ADD, SUB, SLT signed, SLTU unsigned, XOR, OR, AND) compute over 32 bits with wrap-around. Carries out are discarded.
  - Shift amount is `opnum2_in[4:0]`. Bits [31:5] are ignored.
  - When `SERIAL_SHIFT`=1, a shift op with amount k≥1 latches opnum1, k and the function, then enters SHIFT. A shift with k=0 completes in IDLE with result = opnum1.
  - Branches (opcode B-type) compare `reg1_data_in` with `reg2_data_in` per func3: BEQ, BNE, BLT, BGE, BLTU, BGEU.
    - Taken branch: `jump_flag_out`=1, `jump_addr_out` = `inst_addr_in` + `immB_in`.
    - Branch: `reg_we_out`=0.
  - JAL: `result_out` = PC+4; target = PC + `immJ_in`.
  - JALR: `result_out` = PC+4; target = (`reg1_data_in` + `immI_in`) with bit 0 cleared.
  - When `eval_en_in`=0 and the instruction is not a jump or branch: `result_out`=0. `reg_we_out` and `reg_write_addr_out` are passed through.
- In SHIFT, each cycle shifts one bit and decrements the count.
  - SRA fills with the latched bit 31. SLL and SRL fill with 0.
  - When the count reaches 0, the state returns to IDLE and the result registers are written with the latched rd and write enable.
  - Inputs are ignored while in SHIFT. Upstream holds its contents because `hold_req_out`=1.
- `hold_req_out` = (state == SHIFT). It is decoded from the state register, so it is glitch-free.
- `flush_in`=1 at an edge has these effects:
  - State returns to IDLE.
  - `valid_out`, `reg_we_out` and `jump_flag_out` become 0.
  - The latched shift is discarded.
- Flush has priority over the completion of a shift in the same cycle.
- Reset takes effect asynchronously in any state. All outputs go to 0: `reg_we_out`=WriteDisable, `reg_write_addr_out`=ZeroReg, `result_out`=ZeroWord, `jump_addr_out`=0, `valid_out`=0, `jump_flag_out`=0, `hold_req_out`=0.
  - The first edge after `rst` deasserts samples normally.

## Timing
- Non-shift op presented in cycle N produces outputs after edge N+1, with `valid_out`=1 for one cycle.
- Shift with amount k≥1 (serial mode) presented in cycle N:
  - SHIFT is entered at edge N+1.
  - `hold_req_out`=1 during cycles N+1 through N+k.
  - The result appears after edge N+k+1.
  - `valid_out`=0 for every cycle between.
- With `SERIAL_SHIFT`=0, all shifts take 1 cycle and `hold_req_out` stays 0.
- `jump_flag_out` is a 1-cycle pulse, one cycle after the branch or jump is presented. The branch unit outside this block flushes younger stages.
- Back-to-back non-shift ops give one result per cycle.

## Test plan
- Reset, then ADD with opnum1=0xFFFFFFFF and opnum2=2 -> one cycle later `result_out`=0x00000001, `valid_out`=1. Every output was 0 while `rst`=0.
- SLT with opnum1=0xFFFFFFFE and opnum2=1 -> `result_out`=1. SLTU with the same operands -> `result_out`=0.
- SRA with opnum1=0x80000000 and opnum2=0x24 (k=4) -> `hold_req_out` high for exactly 4 cycles, then `result_out`=0xF8000000 with `valid_out`=1. A following instruction held upstream completes one cycle after that.
- SLL with k=0 on opnum1=0x1234 -> `result_out`=0x1234 after 1 cycle with no hold. SLL with k=31 on opnum1=1 -> 0x80000000 after 32 cycles.
- BNE at PC=0x100, immB=0xFFFFFFF8, reg1=3, reg2=4 -> `jump_flag_out`=1, `jump_addr_out`=0xF8, `reg_we_out`=0. JALR with rs1=0x203 and immI=0 -> target 0x202, `result_out`=PC+4.
- Shift with k=10 -> `flush_in` pulse in the 3rd SHIFT cycle returns the block to IDLE and drops `hold_req_out` the next cycle, with no `valid_out`. `rst` asserted mid-SHIFT immediately zeros all outputs.

Source files
------------

// File: rtl/core_ex.sv
// -----------------------------------------------------------------------------
// core_ex -- execute stage of the xRV32I pipeline.
//
// Consumes the operands, ALU function and decoded fields held in the ID/EX
// register. It computes ALU results, resolves branches and jumps, and registers
// the outcome toward the EX/MEM boundary. With SERIAL_SHIFT=1, shifts by k>=1
// run one bit per cycle and stall upstream through hold_req_out for k cycles.
// With SERIAL_SHIFT=0, shifts use a single-cycle barrel shifter.
//
// Ports
//   clk, rst                   clock (rising edge), async active-low reset
//   inst_addr_in               PC of the instruction
//   reg_we_in/reg_write_addr_in  write-back enable / rd
//   reg1_data_in/reg2_data_in  rs1/rs2 values for branch compare and JALR
//   eval_en_in                 ALU enable
//   opnum1_in/opnum2_in        ALU operands
//   func_in                    ALU function code (ALU_* below)
//   opcode_in/func3_in         instruction opcode / func3
//   immB_in/immJ_in/immI_in    sign-extended immediates
//   flush_in                   kill the current instruction, abort a shift
//   reg_we_out/reg_write_addr_out/result_out  registered write-back fields
//   valid_out                  registered fields are meaningful this cycle
//   jump_flag_out/jump_addr_out  registered redirect request and target
//   hold_req_out               stall request for PC, IF/ID and ID/EX
// -----------------------------------------------------------------------------
module core_ex #(
  parameter bit SERIAL_SHIFT = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst_addr_in,
  input  logic        reg_we_in,
  input  logic [4:0]  reg_write_addr_in,
  input  logic [31:0] reg1_data_in,
  input  logic [31:0] reg2_data_in,
  input  logic        eval_en_in,
  input  logic [31:0] opnum1_in,
  input  logic [31:0] opnum2_in,
  input  logic [3:0]  func_in,
  input  logic [6:0]  opcode_in,
  input  logic [2:0]  func3_in,
  input  logic [31:0] immB_in,
  input  logic [31:0] immJ_in,
  input  logic [31:0] immI_in,
  input  logic        flush_in,
  output logic        reg_we_out,
  output logic [4:0]  reg_write_addr_out,
  output logic [31:0] result_out,
  output logic        valid_out,
  output logic        jump_flag_out,
  output logic [31:0] jump_addr_out,
  output logic        hold_req_out
);

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLT  = 4'd2;
  localparam logic [3:0] ALU_SLTU = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_OR   = 4'd5;
  localparam logic [3:0] ALU_AND  = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t      state;
  logic [31:0] sh_val;
  logic [4:0]  sh_cnt;
  logic [3:0]  sh_func;
  logic        sh_we;
  logic [4:0]  sh_rd;

  logic [4:0]  shamt;
  logic        is_branch, is_jal, is_jalr, is_ctrl, is_shift, start_serial;
  logic        br_taken;
  logic [31:0] alu_res, sh_next;
  logic [31:0] nx_result, nx_jaddr;
  logic        nx_we, nx_jump;

  assign shamt     = opnum2_in[4:0];
  assign is_branch = (opcode_in == OPC_BRANCH);
  assign is_jal    = (opcode_in == OPC_JAL);
  assign is_jalr   = (opcode_in == OPC_JALR);
  assign is_ctrl   = is_branch | is_jal | is_jalr;
  assign is_shift  = (func_in == ALU_SLL) | (func_in == ALU_SRL) | (func_in == ALU_SRA);

  // A zero-length shift never enters SHIFT: it finishes in IDLE as opnum1.
  assign start_serial = SERIAL_SHIFT && !is_ctrl && eval_en_in && is_shift &&
                        (shamt != 5'd0);

  // Decoded straight from the state register, so the stall line is glitch-free.
  assign hold_req_out = (state == SHIFT);

  always_comb begin
    // NOTE: every combinationally assigned signal gets a default first so no path leaves it unassigned (which would infer a latch).
    br_taken = 1'b0;
    case (func3_in)
      F3_BEQ:  br_taken = (reg1_data_in == reg2_data_in);
      F3_BNE:  br_taken = (reg1_data_in != reg2_data_in);
      F3_BLT:  br_taken = ($signed(reg1_data_in) <  $signed(reg2_data_in));
      F3_BGE:  br_taken = ($signed(reg1_data_in) >= $signed(reg2_data_in));
      F3_BLTU: br_taken = (reg1_data_in <  reg2_data_in);
      F3_BGEU: br_taken = (reg1_data_in >= reg2_data_in);
      default: br_taken = 1'b0;
    endcase
  end

  always_comb begin
    alu_res = '0;
    case (func_in)
      ALU_ADD:  alu_res = opnum1_in + opnum2_in;
      ALU_SUB:  alu_res = opnum1_in - opnum2_in;
      ALU_SLT:  alu_res = {31'd0, $signed(opnum1_in) < $signed(opnum2_in)};
      ALU_SLTU: alu_res = {31'd0, opnum1_in < opnum2_in};
      ALU_XOR:  alu_res = opnum1_in ^ opnum2_in;
      ALU_OR:   alu_res = opnum1_in | opnum2_in;
      ALU_AND:  alu_res = opnum1_in & opnum2_in;
      ALU_SLL, ALU_SRL, ALU_SRA: begin
        // In serial mode this path only ever sees k=0, so no barrel is built.
        if (SERIAL_SHIFT) begin
          alu_res = opnum1_in;
        end else if (func_in == ALU_SLL) begin
          alu_res = opnum1_in << shamt;
        end else if (func_in == ALU_SRL) begin
          alu_res = opnum1_in >> shamt;
        end else begin
          alu_res = $unsigned($signed(opnum1_in) >>> shamt);
        end
      end
      default:  alu_res = '0;
    endcase
  end

  always_comb begin
    nx_we     = reg_we_in;
    nx_result = '0;
    nx_jump   = 1'b0;
    nx_jaddr  = '0;
    if (is_branch) begin
      nx_we    = 1'b0;
      nx_jump  = br_taken;
      nx_jaddr = br_taken ? (inst_addr_in + immB_in) : '0;
    end else if (is_jal) begin
      nx_result = inst_addr_in + 32'd4;
      nx_jump   = 1'b1;
      nx_jaddr  = inst_addr_in + immJ_in;
    end else if (is_jalr) begin
      nx_result = inst_addr_in + 32'd4;
      nx_jump   = 1'b1;
      nx_jaddr  = (reg1_data_in + immI_in) & 32'hFFFF_FFFE;
    end else if (eval_en_in) begin
      nx_result = alu_res;
    end
  end

  // One bit per cycle; SRA replicates bit 31, which stays the latched sign bit.
  always_comb begin
    sh_next = sh_val;
    case (sh_func)
      ALU_SLL: sh_next = {sh_val[30:0], 1'b0};
      ALU_SRL: sh_next = {1'b0, sh_val[31:1]};
      ALU_SRA: sh_next = {sh_val[31], sh_val[31:1]};
      default: sh_next = sh_val;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state              <= IDLE;
      sh_val             <= '0;
      sh_cnt             <= '0;
      sh_func            <= '0;
      sh_we              <= 1'b0;
      sh_rd              <= '0;
      reg_we_out         <= 1'b0;
      reg_write_addr_out <= '0;
      result_out         <= '0;
      valid_out          <= 1'b0;
      jump_flag_out      <= 1'b0;
      jump_addr_out      <= '0;
    end else if (flush_in) begin
      // Flush wins over everything, including a shift completing this edge.
      state         <= IDLE;
      sh_cnt        <= '0;
      valid_out     <= 1'b0;
      reg_we_out    <= 1'b0;
      jump_flag_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_serial) begin
            state         <= SHIFT;
            sh_val        <= opnum1_in;
            sh_cnt        <= shamt;
            sh_func       <= func_in;
            sh_we         <= reg_we_in;
            sh_rd         <= reg_write_addr_in;
            valid_out     <= 1'b0;
            reg_we_out    <= 1'b0;
            jump_flag_out <= 1'b0;
            jump_addr_out <= '0;
          end else begin
            valid_out          <= 1'b1;
            reg_we_out         <= nx_we;
            reg_write_addr_out <= reg_write_addr_in;
            result_out         <= nx_result;
            jump_flag_out      <= nx_jump;
            jump_addr_out      <= nx_jaddr;
          end
        end
        SHIFT: begin
          sh_val <= sh_next;
          sh_cnt <= sh_cnt - 5'd1;
          if (sh_cnt == 5'd1) begin
            state              <= IDLE;
            result_out         <= sh_next;
            valid_out          <= 1'b1;
            reg_we_out         <= sh_we;
            reg_write_addr_out <= sh_rd;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_core_ex.sv
// -----------------------------------------------------------------------------
// tb_core_ex -- self-checking bench for core_ex (default serial shifter).
// A directed vector table, hand-written multi-cycle sequences (reset, held
// shift, flush, reset mid-shift) and randomized instructions checked against
// a behavioural model computed directly from the instruction semantics.
// -----------------------------------------------------------------------------
module tb_core_ex;

  localparam logic [3:0] F_ADD = 4'd0, F_SUB = 4'd1, F_SLT = 4'd2, F_SLTU = 4'd3,
                         F_XOR = 4'd4, F_OR  = 4'd5, F_AND = 4'd6, F_SLL  = 4'd7,
                         F_SRL = 4'd8, F_SRA = 4'd9;
  localparam logic [6:0] OPC_REG = 7'b0110011, OPC_IMM = 7'b0010011,
                         OPC_BR  = 7'b1100011, OPC_JAL = 7'b1101111,
                         OPC_JALR = 7'b1100111;
  localparam logic [2:0] BEQ = 3'b000, BNE = 3'b001, BLT = 3'b100,
                         BGE = 3'b101, BLTU = 3'b110, BGEU = 3'b111;

  typedef struct {
    logic [31:0] pc;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] r1, r2;
    logic        en;
    logic [31:0] a, b;
    logic [3:0]  func;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [31:0] immb, immj, immi;
  } in_t;

  typedef struct {
    logic [31:0] result;
    logic        we;
    logic [4:0]  rd;
    logic        jump;
    logic [31:0] jaddr;
  } exp_t;

  typedef struct {
    string name;
    in_t   in;
    exp_t  exp;
  } vec_t;

  logic        clk, rst;
  logic [31:0] inst_addr_in, reg1_data_in, reg2_data_in, opnum1_in, opnum2_in;
  logic [31:0] immB_in, immJ_in, immI_in;
  logic        reg_we_in, eval_en_in, flush_in;
  logic [4:0]  reg_write_addr_in;
  logic [3:0]  func_in;
  logic [6:0]  opcode_in;
  logic [2:0]  func3_in;
  logic        reg_we_out, valid_out, jump_flag_out, hold_req_out;
  logic [4:0]  reg_write_addr_out;
  logic [31:0] result_out, jump_addr_out;

  int n_vec;
  int n_bad;
  vec_t tbl[$];

  core_ex dut (
    .clk(clk), .rst(rst),
    .inst_addr_in(inst_addr_in), .reg_we_in(reg_we_in),
    .reg_write_addr_in(reg_write_addr_in),
    .reg1_data_in(reg1_data_in), .reg2_data_in(reg2_data_in),
    .eval_en_in(eval_en_in), .opnum1_in(opnum1_in), .opnum2_in(opnum2_in),
    .func_in(func_in), .opcode_in(opcode_in), .func3_in(func3_in),
    .immB_in(immB_in), .immJ_in(immJ_in), .immI_in(immI_in),
    .flush_in(flush_in),
    .reg_we_out(reg_we_out), .reg_write_addr_out(reg_write_addr_out),
    .result_out(result_out), .valid_out(valid_out),
    .jump_flag_out(jump_flag_out), .jump_addr_out(jump_addr_out),
    .hold_req_out(hold_req_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, want %b", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input in_t i);
    inst_addr_in      = i.pc;
    reg_we_in         = i.we;
    reg_write_addr_in = i.rd;
    reg1_data_in      = i.r1;
    reg2_data_in      = i.r2;
    eval_en_in        = i.en;
    opnum1_in         = i.a;
    opnum2_in         = i.b;
    func_in           = i.func;
    opcode_in         = i.opc;
    func3_in          = i.f3;
    immB_in           = i.immb;
    immJ_in           = i.immj;
    immI_in           = i.immi;
  endtask

  function automatic in_t base();
    in_t i;
    i.pc = 32'h100; i.we = 1'b1; i.rd = 5'd5; i.r1 = '0; i.r2 = '0;
    i.en = 1'b1; i.a = '0; i.b = '0; i.func = F_ADD; i.opc = OPC_REG;
    i.f3 = BEQ; i.immb = '0; i.immj = '0; i.immi = '0;
    return i;
  endfunction

  function automatic in_t alu(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
    in_t i = base();
    i.func = f; i.a = a; i.b = b;
    return i;
  endfunction

  function automatic in_t br(input logic [2:0] f3, input logic [31:0] pc,
                             input logic [31:0] r1, input logic [31:0] r2,
                             input logic [31:0] immb);
    in_t i = base();
    i.opc = OPC_BR; i.f3 = f3; i.pc = pc; i.r1 = r1; i.r2 = r2; i.immb = immb;
    return i;
  endfunction

  function automatic exp_t ex(input logic [31:0] result, input logic we,
                              input logic [4:0] rd, input logic jump,
                              input logic [31:0] jaddr);
    exp_t e;
    e.result = result; e.we = we; e.rd = rd; e.jump = jump; e.jaddr = jaddr;
    return e;
  endfunction

  task automatic add_vec(input string name, input in_t i, input exp_t e);
    vec_t v;
    v.name = name; v.in = i; v.exp = e;
    tbl.push_back(v);
  endtask

  // Behavioural reference: instruction semantics in plain arithmetic.
  function automatic exp_t model(input in_t i);
    exp_t e;
    logic taken;
    int   k;
    e = ex('0, i.we, i.rd, 1'b0, '0);
    k = int'(i.b % 32);
    taken = 1'b0;
    if (i.opc == OPC_BR) begin
      case (i.f3)
        BEQ:  taken = (i.r1 == i.r2);
        BNE:  taken = (i.r1 != i.r2);
        BLT:  taken = ($signed(i.r1) <  $signed(i.r2));
        BGE:  taken = ($signed(i.r1) >= $signed(i.r2));
        BLTU: taken = (i.r1 <  i.r2);
        BGEU: taken = (i.r1 >= i.r2);
        default: taken = 1'b0;
      endcase
      e.we = 1'b0;
      if (taken) begin
        e.jump = 1'b1;
        e.jaddr = i.pc + i.immb;
      end
    end else if (i.opc == OPC_JAL) begin
      e.result = i.pc + 32'd4; e.jump = 1'b1; e.jaddr = i.pc + i.immj;
    end else if (i.opc == OPC_JALR) begin
      e.result = i.pc + 32'd4; e.jump = 1'b1;
      e.jaddr = ((i.r1 + i.immi) / 2) * 2;
    end else if (i.en) begin
      case (i.func)
        F_ADD:  e.result = i.a + i.b;
        F_SUB:  e.result = i.a - i.b;
        F_SLT:  e.result = ($signed(i.a) < $signed(i.b)) ? 32'd1 : 32'd0;
        F_SLTU: e.result = (i.a < i.b) ? 32'd1 : 32'd0;
        F_XOR:  e.result = i.a ^ i.b;
        F_OR:   e.result = i.a | i.b;
        F_AND:  e.result = i.a & i.b;
        F_SLL:  e.result = i.a << k;
        F_SRL:  e.result = i.a >> k;
        F_SRA:  e.result = $unsigned($signed(i.a) >>> k);
        default: e.result = '0;
      endcase
    end
    return e;
  endfunction

  // Number of SHIFT cycles the instruction occupies in serial mode.
  function automatic int shift_len(input in_t i);
    if (i.opc == OPC_BR || i.opc == OPC_JAL || i.opc == OPC_JALR) return 0;
    if (!i.en) return 0;
    if (i.func != F_SLL && i.func != F_SRL && i.func != F_SRA) return 0;
    return int'(i.b % 32);
  endfunction

  function automatic in_t rnd_in();
    in_t i;
    logic [2:0] f3s [6];
    logic [31:0] t;
    int c;
    f3s = '{BEQ, BNE, BLT, BGE, BLTU, BGEU};
    c = int'($urandom_range(0, 9));
    t = $urandom;
    i.pc   = {t[31:2], 2'b00};
    i.we   = t[0];
    i.rd   = t[7:3];
    i.r1   = $urandom;
    i.r2   = ($urandom_range(0, 3) == 0) ? i.r1 : $urandom;
    i.en   = ($urandom_range(0, 7) != 0);
    i.a    = $urandom;
    i.b    = $urandom;
    i.func = 4'($urandom_range(0, 9));
    i.opc  = t[8] ? OPC_REG : OPC_IMM;
    i.f3   = f3s[$urandom_range(0, 5)];
    i.immb = $urandom;
    i.immj = $urandom;
    i.immi = $urandom;
    if (c == 7) i.opc = OPC_BR;
    if (c == 8) i.opc = OPC_JAL;
    if (c == 9) i.opc = OPC_JALR;
    return i;
  endfunction

  task automatic check_all(input string name, input exp_t e);
    check({name, ".result"}, result_out, e.result);
    check1({name, ".we"}, reg_we_out, e.we);
    check({name, ".rd"}, 32'(reg_write_addr_out), 32'(e.rd));
    check1({name, ".jump"}, jump_flag_out, e.jump);
    check({name, ".jaddr"}, jump_addr_out, e.jaddr);
    check1({name, ".valid"}, valid_out, 1'b1);
    check1({name, ".hold"}, hold_req_out, 1'b0);
  endtask

  task automatic check_zero(input string name);
    check({name, ".result"}, result_out, 32'd0);
    check1({name, ".we"}, reg_we_out, 1'b0);
    check({name, ".rd"}, 32'(reg_write_addr_out), 32'd0);
    check1({name, ".jump"}, jump_flag_out, 1'b0);
    check({name, ".jaddr"}, jump_addr_out, 32'd0);
    check1({name, ".valid"}, valid_out, 1'b0);
    check1({name, ".hold"}, hold_req_out, 1'b0);
  endtask

  // Present one instruction; for a serial shift, verify the exact hold
  // window while scrambling the (ignored) inputs, then check the result.
  task automatic apply_exp(input string name, input in_t i, input exp_t e);
    int k;
    k = shift_len(i);
    drive(i);
    step();
    if (k > 0) begin
      check1({name, ".hold_first"}, hold_req_out, 1'b1);
      check1({name, ".valid_first"}, valid_out, 1'b0);
      drive(rnd_in());
      for (int j = 1; j < k; j++) begin
        step();
        check1({name, ".hold_mid"}, hold_req_out, 1'b1);
        check1({name, ".valid_mid"}, valid_out, 1'b0);
      end
      step();
    end
    check_all(name, e);
  endtask

  initial begin
    in_t  i, nxt;
    int   hc;

    n_vec = 0;
    n_bad = 0;
    flush_in = 1'b0;
    rst = 1'b1;
    drive(rnd_in());
    #1 rst = 1'b0;

    // Reset: outputs stay zero across edges with random inputs applied.
    repeat (3) begin
      drive(rnd_in());
      step();
    end
    check_zero("reset");

    // First edge after release samples normally.
    drive(alu(F_ADD, 32'hFFFF_FFFF, 32'd2));
    rst = 1'b1;
    step();
    check_all("first_after_reset", ex(32'd1, 1'b1, 5'd5, 1'b0, 32'd0));

    // Directed table.
    add_vec("sub_neg", alu(F_SUB, 32'd5, 32'd7), ex(32'hFFFF_FFFE, 1'b1, 5'd5, 1'b0, 32'd0));
    add_vec("slt",  alu(F_SLT,  32'hFFFF_FFFE, 32'd1), ex(32'd1, 1'b1, 5'd5, 1'b0, 32'd0));
    add_vec("sltu", alu(F_SLTU, 32'hFFFF_FFFE, 32'd1), ex(32'd0, 1'b1, 5'd5, 1'b0, 32'd0));
    add_vec("xor",  alu(F_XOR, 32'h0000_F0F0, 32'h0000_0FF0), ex(32'h0000_FF00, 1'b1, 5'd5, 1'b0, 32'd0));
    add_vec("or",   alu(F_OR,  32'hF000_0000, 32'h1), ex(32'hF000_0001, 1'b1, 5'd5, 1'b0, 32'd0));
    add_vec("and",  alu(F_AND, 32'hFF00_FF00, 32'h0F0F_0F0F), ex(32'h0F00_0F00, 1'b1, 5'd5, 1'b0, 32'd0));
    add_vec("sll_k0", alu(F_SLL, 32'h1234, 32'h20), ex(32'h1234, 1'b1, 5'd5, 1'b0, 32'd0));
    add_vec("srl_k0", alu(F_SRL, 32'h8000_0001, 32'h0), ex(32'h8000_0001, 1'b1, 5'd5, 1'b0, 32'd0));
    add_vec("sll_k31", alu(F_SLL, 32'h1, 32'd31), ex(32'h8000_0000, 1'b1, 5'd5, 1'b0, 32'd0));
    add_vec("srl_k31", alu(F_SRL, 32'h8000_0000, 32'h3F), ex(32'h1, 1'b1, 5'd5, 1'b0, 32'd0));
    add_vec("sra_k1", alu(F_SRA, 32'h8000_0000, 32'd1), ex(32'hC000_0000, 1'b1, 5'd5, 1'b0, 32'd0));
    i = alu(F_ADD, 32'd5, 32'd6); i.en = 1'b0; i.rd = 5'd9;
    add_vec("en_off", i, ex(32'd0, 1'b1, 5'd9, 1'b0, 32'd0));
    i = alu(F_SRA, 32'h8000_0000, 32'd4); i.en = 1'b0;
    add_vec("en_off_sra", i, ex(32'd0, 1'b1, 5'd5, 1'b0, 32'd0));
    add_vec("bne_taken", br(BNE, 32'h100, 32'd3, 32'd4, 32'hFFFF_FFF8), ex(32'd0, 1'b0, 5'd5, 1'b1, 32'hF8));
    add_vec("beq_not",   br(BEQ, 32'h100, 32'd1, 32'd2, 32'h40), ex(32'd0, 1'b0, 5'd5, 1'b0, 32'd0));
    add_vec("beq_taken", br(BEQ, 32'h300, 32'd7, 32'd7, 32'h8), ex(32'd0, 1'b0, 5'd5, 1'b1, 32'h308));
    add_vec("bge_not",   br(BGE, 32'h200, 32'hFFFF_FFFF, 32'd1, 32'h10), ex(32'd0, 1'b0, 5'd5, 1'b0, 32'd0));
    add_vec("bgeu_taken", br(BGEU, 32'h200, 32'hFFFF_FFFF, 32'd1, 32'h10), ex(32'd0, 1'b0, 5'd5, 1'b1, 32'h210));
    add_vec("blt_taken", br(BLT, 32'h200, 32'hFFFF_FFFF, 32'd1, 32'h10), ex(32'd0, 1'b0, 5'd5, 1'b1, 32'h210));
    add_vec("bltu_not",  br(BLTU, 32'h200, 32'hFFFF_FFFF, 32'd1, 32'h10), ex(32'd0, 1'b0, 5'd5, 1'b0, 32'd0));
    i = base(); i.opc = OPC_JALR; i.pc = 32'h400; i.r1 = 32'h203; i.immi = 32'd0;
    add_vec("jalr", i, ex(32'h404, 1'b1, 5'd5, 1'b1, 32'h202));
    i = base(); i.opc = OPC_JALR; i.pc = 32'h400; i.r1 = 32'h1000; i.immi = 32'hFFFF_FFFF;
    add_vec("jalr_neg", i, ex(32'h404, 1'b1, 5'd5, 1'b1, 32'hFFE));
    i = base(); i.opc = OPC_JAL; i.pc = 32'h1000; i.immj = 32'h20; i.en = 1'b0;
    add_vec("jal", i, ex(32'h1004, 1'b1, 5'd5, 1'b1, 32'h1020));

    foreach (tbl[n]) apply_exp(tbl[n].name, tbl[n].in, tbl[n].exp);

    // SRA k=4 with the next instruction held upstream during the stall.
    drive(alu(F_SRA, 32'h8000_0000, 32'h24));
    step();
    nxt = alu(F_ADD, 32'd10, 32'd20); nxt.rd = 5'd7;
    drive(nxt);
    hc = 0;
    for (int c = 0; c < 40 && hold_req_out === 1'b1; c++) begin
      hc++;
      check1("sra_hold_valid", valid_out, 1'b0);
      step();
    end
    check("sra_hold_cycles", 32'(hc), 32'd4);
    check_all("sra_result", ex(32'hF800_0000, 1'b1, 5'd5, 1'b0, 32'd0));
    step();
    check_all("held_add", ex(32'd30, 1'b1, 5'd7, 1'b0, 32'd0));

    // Flush in the 3rd SHIFT cycle of a k=10 shift.
    drive(alu(F_SRL, 32'hFFFF_0000, 32'd10));
    step();
    step();
    step();
    check1("flush_pre_hold", hold_req_out, 1'b1);
    flush_in = 1'b1;
    step();
    flush_in = 1'b0;
    check1("flush.hold", hold_req_out, 1'b0);
    check1("flush.valid", valid_out, 1'b0);
    check1("flush.we", reg_we_out, 1'b0);
    check1("flush.jump", jump_flag_out, 1'b0);
    nxt = alu(F_ADD, 32'd7, 32'd8); nxt.rd = 5'd3;
    drive(nxt);
    step();
    check_all("after_flush", ex(32'd15, 1'b1, 5'd3, 1'b0, 32'd0));

    // Flush on the edge a k=2 shift would complete: flush wins.
    drive(alu(F_SLL, 32'h1, 32'd2));
    step();
    step();
    flush_in = 1'b1;
    step();
    flush_in = 1'b0;
    check1("flush_vs_done.valid", valid_out, 1'b0);
    check1("flush_vs_done.hold", hold_req_out, 1'b0);

    // Flush of a jump in IDLE.
    i = base(); i.opc = OPC_JAL; i.immj = 32'h40;
    drive(i);
    flush_in = 1'b1;
    step();
    flush_in = 1'b0;
    check1("flush_jal.jump", jump_flag_out, 1'b0);
    check1("flush_jal.valid", valid_out, 1'b0);
    check1("flush_jal.we", reg_we_out, 1'b0);

    // Reset mid-SHIFT zeros outputs without waiting for an edge.
    drive(alu(F_SRA, 32'h8765_4321, 32'd10));
    step();
    step();
    check1("pre_rst_hold", hold_req_out, 1'b1);
    #2 rst = 1'b0;
    #1 check_zero("rst_mid_shift");
    step();
    check_zero("rst_mid_shift_edge");
    rst = 1'b1;

    // Randomized instructions against the behavioural model.
    for (int n = 0; n < 300; n++) begin
      i = rnd_in();
      apply_exp($sformatf("rand%0d", n), i, model(i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
